// File: rtl/arc_mem_pkg.sv
// Shared types for the MEM-stage data-memory access unit.
//   mem_size_e   : access size encoding from EX/MEM (3 is reserved, handled as word)
//   dmem_state_e : access FSM states
//   dmem_req_t   : latched bus request held stable while waiting for ack
package arc_mem_pkg;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} dmem_state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_access_if.sv
// Data-memory req/ack bus.
//   master (access unit): drives req, we, addr, wdata, be; receives ack, rdata
//   slave  (memory)     : the reverse
// rdata is valid in the same cycle as ack for loads.
interface dmem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/dmem_store_align.sv
// Combinational store-lane steering and alignment check.
//   size     : access size (0 byte, 1 half, 2/3 word)
//   addr_lo  : effective address bits [1:0]
//   storeval : register value to store
//   wdata    : value replicated across the lanes the size covers
//   be       : little-endian byte enables for the addressed lanes
//   misalign : half on odd address, or word on non-word-aligned address
module dmem_store_align
  import arc_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] storeval,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misalign
);

  always_comb begin
    wdata    = storeval;
    be       = BE_ALL;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{storeval[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata    = {2{storeval[15:0]}};
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      // word and the reserved encoding
      default: misalign = |addr_lo;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data-memory access unit.
// Issues one load/store per instruction over the dmem req/ack bus, stalls the
// front of the pipeline until it retires, and presents the raw read word to MEM/WB.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_data_alures           : effective address
//   i_data_storeval         : store value
//   i_con_Mmemread/write    : load / store in MEM (both set = load)
//   i_con_Msize             : access size
//   i_con_Mregwrite         : regwrite from EX/MEM
//   o_con_Mregwrite         : regwrite to MEM/WB, squashed while stalled/faulted
//   o_data_memout           : captured read word
//   o_stall                 : pipeline freeze
//   o_excp_misalign         : misaligned access flag
//   o_err_timeout           : timeout abort pulse
//   dmem                    : memory bus (master side)
// Build option: DMEM_TIMEOUT_EN adds a REQ watchdog that aborts after
// TIMEOUT_CYCLES cycles without ack and returns ERR_WORD.
module dmem_access
  import arc_mem_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data_alures,
  input  logic [31:0] i_data_storeval,
  input  logic        i_con_Mmemread,
  input  logic        i_con_Mmemwrite,
  input  logic [1:0]  i_con_Msize,
  input  logic        i_con_Mregwrite,
  output logic        o_con_Mregwrite,
  output logic [31:0] o_data_memout,
  output logic        o_stall,
  output logic        o_excp_misalign,
  output logic        o_err_timeout,
  dmem_access_if.master dmem
);

  dmem_state_e state, state_nxt;
  dmem_req_t   req_q;
  logic        req_vld;
  logic [31:0] rdata_q;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        misalign;
  logic        op;
  logic        tmo_hit;

  assign op = i_con_Mmemread | i_con_Mmemwrite;

  dmem_store_align u_align (
    .size     (i_con_Msize),
    .addr_lo  (i_data_alures[1:0]),
    .storeval (i_data_storeval),
    .wdata    (st_wdata),
    .be       (st_be),
    .misalign (misalign)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;

  assign tmo_hit       = (state == ST_REQ) && !dmem.ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_err_timeout = err_q;

  // Counts cycles spent in REQ; the abort pulse lands in the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state == ST_REQ) ? cnt + 1'b1 : '0;
      err_q <= tmo_hit;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg    = 32'(TIMEOUT_CYCLES) ^ ERR_WORD;
  assign tmo_hit       = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    o_stall         = 1'b0;
    o_excp_misalign = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op) begin
          if (misalign) begin
            o_excp_misalign = 1'b1;
          end else begin
            o_stall   = 1'b1;
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        o_stall = 1'b1;
        if (dmem.ack || tmo_hit) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A faulted access never writes back; o_err_timeout is only high in DONE.
  assign o_con_Mregwrite = i_con_Mregwrite & ~o_stall & ~o_excp_misalign & ~o_err_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      req_vld <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op && !misalign) begin
            req_vld    <= 1'b1;
            // memread wins when both are set
            req_q.we    <= ~i_con_Mmemread;
            req_q.addr  <= {i_data_alures[31:2], 2'b00};
            req_q.wdata <= i_con_Mmemread ? 32'h0 : st_wdata;
            req_q.be    <= i_con_Mmemread ? BE_ALL : st_be;
          end
        end
        ST_REQ: begin
          if (dmem.ack) begin
            req_vld <= 1'b0;
            if (!req_q.we) rdata_q <= dmem.rdata;
          end else if (tmo_hit) begin
            req_vld <= 1'b0;
            rdata_q <= ERR_WORD;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.req      = req_vld;
  assign dmem.we       = req_q.we;
  assign dmem.addr     = req_q.addr;
  assign dmem.wdata    = req_q.wdata;
  assign dmem.be       = req_q.be;
  assign o_data_memout = rdata_q;

endmodule

// File: tb/tb_dmem_access.sv
// Directed bench for dmem_access; expected values are hand-computed per vector.
module tb_dmem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alures, storeval;
  logic        memread, memwrite, regwrite_in;
  logic [1:0]  size;
  logic        regwrite_out, stall, excp_misalign, err_timeout;
  logic [31:0] memout;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_stall;
  int          n_req;

  dmem_access_if dmem ();

  dmem_access #(.TIMEOUT_CYCLES(4), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_data_alures   (alures),
    .i_data_storeval (storeval),
    .i_con_Mmemread  (memread),
    .i_con_Mmemwrite (memwrite),
    .i_con_Msize     (size),
    .i_con_Mregwrite (regwrite_in),
    .o_con_Mregwrite (regwrite_out),
    .o_data_memout   (memout),
    .o_stall         (stall),
    .o_excp_misalign (excp_misalign),
    .o_err_timeout   (err_timeout),
    .dmem            (dmem.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] v, input logic rw);
    memread = rd; memwrite = wr; size = sz; alures = a; storeval = v; regwrite_in = rw;
  endtask

  initial begin
    rst = 1'b1;
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 0);
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    tick; tick;

    // reset state
    chk("rst_req",    dmem.req,      0);
    chk("rst_we",     dmem.we,       0);
    chk("rst_addr",   dmem.addr,     0);
    chk("rst_wdata",  dmem.wdata,    0);
    chk("rst_be",     dmem.be,       0);
    chk("rst_memout", memout,        0);
    chk("rst_stall",  stall,         0);
    chk("rst_mis",    excp_misalign, 0);
    chk("rst_err",    err_timeout,   0);
    rst = 1'b0;
    tick;

    // 1: load word 0x100, immediate ack
    set_op(1, 0, 2'd2, 32'h100, 32'h0, 1); #1;
    chk("t1_idle_stall", stall, 1);
    chk("t1_idle_rw",    regwrite_out, 0);
    chk("t1_idle_req",   dmem.req, 0);
    tick;
    chk("t1_req",    dmem.req, 1);
    chk("t1_addr",   dmem.addr, 32'h100);
    chk("t1_we",     dmem.we, 0);
    chk("t1_be",     dmem.be, 4'hF);
    chk("t1_wdata",  dmem.wdata, 0);
    chk("t1_stall",  stall, 1);
    chk("t1_rw_req", regwrite_out, 0);
    dmem.ack = 1; dmem.rdata = 32'h1234_5678;
    tick;
    dmem.ack = 0; dmem.rdata = 32'h0; #1;
    chk("t1_done_req",    dmem.req, 0);
    chk("t1_done_stall",  stall, 0);
    chk("t1_done_memout", memout, 32'h1234_5678);
    chk("t1_done_rw",     regwrite_out, 1);
    tick;
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 0);
    #1 chk("t1_idle_after", stall, 0);

    // 2: store byte 0x203, ack on the 4th REQ cycle
    set_op(0, 1, 2'd0, 32'h203, 32'h0000_00AB, 0); #1;
    n_stall = stall;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem.ack = 1;
      #1;
      chk("t2_req",   dmem.req, 1);
      chk("t2_we",    dmem.we, 1);
      chk("t2_addr",  dmem.addr, 32'h200);
      chk("t2_wdata", dmem.wdata, 32'hABAB_ABAB);
      chk("t2_be",    dmem.be, 4'b1000);
      n_stall += stall;
      tick;
      dmem.ack = 0;
    end
    #1;
    chk("t2_done_req", dmem.req, 0);
    chk("t2_done_stall", stall, 0);
    chk("t2_stall_cycles", n_stall, 5);
    chk("t2_memout_kept", memout, 32'h1234_5678);
    tick;

    // 3a: store half 0x202
    set_op(0, 1, 2'd1, 32'h202, 32'h0000_CAFE, 0);
    tick;
    chk("t3_be",    dmem.be, 4'b1100);
    chk("t3_wdata", dmem.wdata, 32'hCAFE_CAFE);
    chk("t3_addr",  dmem.addr, 32'h200);
    dmem.ack = 1;
    tick;
    dmem.ack = 0;
    tick;
    // 3b: misaligned load word 0x102
    set_op(1, 0, 2'd2, 32'h102, 32'h0, 1); #1;
    chk("t3_mis",       excp_misalign, 1);
    chk("t3_mis_stall", stall, 0);
    chk("t3_mis_rw",    regwrite_out, 0);
    tick;
    chk("t3_mis_noreq", dmem.req, 0);
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 1); #1;
    chk("t3_mis_clear", excp_misalign, 0);
    chk("t3_rw_pass",   regwrite_out, 1);
    tick;

    // 4: back-to-back loads 0x10 then 0x14 (second with memwrite too -> load)
    n_req = 0; n_stall = 0;
    set_op(1, 0, 2'd2, 32'h10, 32'h0, 1); #1;
    n_stall += stall;
    tick;
    chk("t4a_addr", dmem.addr, 32'h10);
    n_req += dmem.req; n_stall += stall;
    dmem.ack = 1; dmem.rdata = 32'h1111_0010;
    tick;
    dmem.ack = 0;
    n_req += dmem.req; n_stall += stall;
    chk("t4a_memout", memout, 32'h1111_0010);
    tick;
    set_op(1, 1, 2'd2, 32'h14, 32'h5555_5555, 1); #1;
    n_stall += stall;
    chk("t4b_stall", stall, 1);
    tick;
    chk("t4b_addr",  dmem.addr, 32'h14);
    chk("t4b_we",    dmem.we, 0);
    chk("t4b_wdata", dmem.wdata, 0);
    n_req += dmem.req; n_stall += stall;
    dmem.ack = 1; dmem.rdata = 32'h2222_0014;
    tick;
    dmem.ack = 0;
    n_req += dmem.req; n_stall += stall;
    chk("t4b_memout", memout, 32'h2222_0014);
    chk("t4_req_cycles", n_req, 2);
    chk("t4_stall_cycles", n_stall, 4);
    tick;
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 0); #1;
    chk("t4_no_dup", dmem.req, 0);
    tick;

    // 5: reset while in REQ, late ack afterwards
    set_op(1, 0, 2'd2, 32'h100, 32'h0, 1);
    tick;
    chk("t5_req", dmem.req, 1);
    rst = 1;
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 0);
    tick;
    rst = 0;
    dmem.ack = 1; dmem.rdata = 32'h9999_9999; #1;
    chk("t5_req_drop", dmem.req, 0);
    chk("t5_stall",    stall, 0);
    chk("t5_addr",     dmem.addr, 0);
    chk("t5_be",       dmem.be, 0);
    tick;
    dmem.ack = 0;
    chk("t5_ack_ign",  memout, 0);
    chk("t5_req_idle", dmem.req, 0);
    chk("t5_stall2",   stall, 0);
    tick;

`ifdef DMEM_TIMEOUT_EN
    // 6: no ack, watchdog aborts after 4 REQ cycles
    n_req = 0;
    set_op(1, 0, 2'd2, 32'h100, 32'h0, 1);
    tick;
    for (int i = 0; i < 20 && dmem.req; i++) begin
      n_req++;
      tick;
    end
    chk("t6_req_cycles", n_req, 4);
    chk("t6_err",    err_timeout, 1);
    chk("t6_memout", memout, 32'hDEAD_BEEF);
    chk("t6_rw",     regwrite_out, 0);
    chk("t6_stall",  stall, 0);
    tick;
    set_op(0, 0, 2'd0, 32'h0, 32'h0, 0); #1;
    chk("t6_err_pulse", err_timeout, 0);
`else
    chk("t6_err_tied", err_timeout, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
